// File: rtl/wc_fifo_fwft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wc_fifo_fwft_pkg
//  Description : Shared constants/helpers for the FWFT FIFO bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package wc_fifo_fwft_pkg;

  // Almost-full default leaves two words of headroom below RAM depth.
  function automatic int afullDefault(input int addrWidth);
    return (2 ** addrWidth) - 2;
  endfunction

  // Level spans RAM depth plus the output stage, hence one extra bit.
  function automatic int levelWidth(input int addrWidth);
    return addrWidth + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_1rd1wr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_1rd1wr
//  Description : Simple dual-port RAM, write on port A, registered read on B.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_1rd1wr #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clkA,
  input  logic                  wrEnA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] dinA,
  input  logic                  clkB,
  input  logic                  rdEnB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  output logic [DATA_WIDTH-1:0] doutB
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clkA) begin
    if (wrEnA) r_mem[addrA] <= dinA;
  end

  always_ff @(posedge clkB) begin
    if (rdEnB) doutB <= r_mem[addrB];
  end

endmodule
`default_nettype wire

// File: rtl/wc_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : wc_fifo_fwft
//  Description : First-word-fall-through FIFO over fifo_1rd1wr with a hold
//                register on the output. Define WC_FIFO_AFULL_EN for afull.
//  Revision    : 1.0 - initial release
// ============================================================================
module wc_fifo_fwft
  import wc_fifo_fwft_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int AFULL_LVL  = afullDefault(ADDR_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic [levelWidth(ADDR_WIDTH)-1:0]   level,
  output logic                                afull
);

  localparam int c_LEVEL_W = levelWidth(ADDR_WIDTH);

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [c_LEVEL_W-1:0]  level_t;

  localparam level_t c_DEPTH = level_t'(2 ** ADDR_WIDTH);

  ptr_t                  r_wrPtr;
  ptr_t                  r_rdPtr;
  level_t                r_ramCount;
  level_t                r_level;
  level_t                w_ramCountNext;
  level_t                w_levelNext;
  logic                  r_inFlight;
  logic                  r_holdValid;
  logic [DATA_WIDTH-1:0] r_holdData;
  logic [DATA_WIDTH-1:0] w_ramDout;
  logic                  w_wrFire;
  logic                  w_rdFire;
  logic                  w_issue;

  assign wr_ready = (r_ramCount != c_DEPTH);
  assign w_wrFire = wr_valid & wr_ready;
  assign rd_valid = r_inFlight | r_holdValid;
  // Returning RAM data goes straight out; the hold register only covers stalls.
  assign rd_data  = r_inFlight ? w_ramDout : r_holdData;
  assign w_rdFire = rd_valid & rd_ready;
  assign w_issue  = (r_ramCount != '0) & (~rd_valid | rd_ready);
  assign level    = r_level;

  always_comb begin
    w_ramCountNext = r_ramCount;
    w_levelNext    = r_level;
    if (w_wrFire && !w_issue)      w_ramCountNext = r_ramCount + level_t'(1);
    else if (!w_wrFire && w_issue) w_ramCountNext = r_ramCount - level_t'(1);
    if (w_wrFire && !w_rdFire)      w_levelNext = r_level + level_t'(1);
    else if (!w_wrFire && w_rdFire) w_levelNext = r_level - level_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_ramCount  <= '0;
      r_level     <= '0;
      r_inFlight  <= 1'b0;
      r_holdValid <= 1'b0;
      r_holdData  <= '0;
    end else begin
      if (w_wrFire) r_wrPtr <= r_wrPtr + ptr_t'(1);
      if (w_issue)  r_rdPtr <= r_rdPtr + ptr_t'(1);
      r_ramCount <= w_ramCountNext;
      r_level    <= w_levelNext;
      r_inFlight <= w_issue;
      // A read is only issued into an empty/draining stage, so hold and
      // in-flight are never both set.
      if (r_inFlight && !rd_ready) begin
        r_holdValid <= 1'b1;
        r_holdData  <= w_ramDout;
      end else if (w_rdFire) begin
        r_holdValid <= 1'b0;
      end
    end
  end

`ifdef WC_FIFO_AFULL_EN
  localparam level_t c_AFULL = level_t'(AFULL_LVL);
  logic r_afull;

  always_ff @(posedge clk) begin
    if (rst) r_afull <= 1'b0;
    else     r_afull <= (w_levelNext >= c_AFULL);
  end

  assign afull = r_afull;
`else
  assign afull = 1'b0;
`endif

  fifo_1rd1wr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clkA  (clk),
    .wrEnA (w_wrFire),
    .addrA (r_wrPtr),
    .dinA  (wr_data),
    .clkB  (clk),
    .rdEnB (w_issue),
    .addrB (r_rdPtr),
    .doutB (w_ramDout)
  );

endmodule
`default_nettype wire

// File: tb/tb_wc_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wc_fifo_fwft
//  Description : Scoreboard bench for wc_fifo_fwft (ADDR_WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wc_fifo_fwft;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        wr_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic [31:0] wr_data  = '0;
  logic        wr_ready;
  logic        rd_valid;
  logic        afull;
  logic [31:0] rd_data;
  logic [4:0]  level;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  wc_fifo_fwft #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .afull    (afull)
  );

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Records handshakes before the edge, then checks level/afull after it.
  task automatic cycle();
    logic expAfull;
    if (rst) sb.delete();
    else begin
      if (wr_valid && wr_ready) sb.push_back(wr_data);
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) checkVal("spuriousRead", 64'(rd_valid), 64'd0);
        else checkVal("rdData", 64'(rd_data), 64'(sb.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    checkVal("level", 64'(level), 64'(sb.size()));
`ifdef WC_FIFO_AFULL_EN
    expAfull = (sb.size() >= 14);
`else
    expAfull = 1'b0;
`endif
    checkVal("afull", 64'(afull), 64'(expAfull));
  endtask

  task automatic drain();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int t = 0; t < 60 && (sb.size() != 0 || rd_valid); t++) cycle();
    checkVal("drainEmpty", 64'(sb.size()), 64'd0);
    checkVal("drainValid", 64'(rd_valid), 64'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    repeat (3) cycle();
    checkVal("rstRdValid", 64'(rd_valid), 64'd0);
    checkVal("rstWrReady", 64'(wr_ready), 64'd1);
    checkVal("rstRdData",  64'(rd_data),  64'd0);
    rst = 1'b0;

    // single write, latency two cycles
    wr_valid = 1'b1;
    wr_data  = 32'hA5A5_0001;
    rd_ready = 1'b0;
    cycle();
    wr_valid = 1'b0;
    checkVal("lat1Valid", 64'(rd_valid), 64'd0);
    cycle();
    checkVal("lat2Valid", 64'(rd_valid), 64'd1);
    checkVal("lat2Data",  64'(rd_data),  64'hA5A5_0001);
    checkVal("lat2Level", 64'(level),    64'd1);
    drain();

    // fill to 17 with no reads
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h1000_0000 + i;
      checkVal("fillWrReady", 64'(wr_ready), 64'd1);
      cycle();
    end
    wr_data = 32'h1000_0011;
    checkVal("fullWrReady", 64'(wr_ready), 64'd0);
    checkVal("fullLevel",   64'(level),    64'd17);
    cycle();

    // full, toggling consumer with writer always offering
    for (int k = 0; k < 24; k++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h2000_0000 + k;
      rd_ready = (k % 2 == 0);
      cycle();
      checkVal("toggleRange", 64'(level >= 5'd16 && level <= 5'd17), 64'd1);
    end
    drain();

    // 40-word stream across two pointer wraps
    for (int k = 0; k < 42; k++) begin
      wr_valid = (k < 40);
      wr_data  = 32'h3000_0000 + k;
      rd_ready = 1'b1;
      checkVal("streamValid", 64'(rd_valid), 64'(k >= 2));
      cycle();
    end
    drain();

    // reset at level 9 with a read in flight
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h4000_0000 + i;
      cycle();
    end
    wr_data  = 32'h4000_0009;
    rd_ready = 1'b1;
    cycle();
    checkVal("preRstLevel", 64'(level), 64'd9);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    rst      = 1'b1;
    cycle();
    rst = 1'b0;
    checkVal("midRstValid",   64'(rd_valid), 64'd0);
    checkVal("midRstLevel",   64'(level),    64'd0);
    checkVal("midRstWrReady", 64'(wr_ready), 64'd1);
    checkVal("midRstRdData",  64'(rd_data),  64'd0);
    wr_valid = 1'b1;
    wr_data  = 32'h0000_1234;
    cycle();
    wr_valid = 1'b0;
    for (int t = 0; t < 5 && !rd_valid; t++) cycle();
    checkVal("postRstValid", 64'(rd_valid), 64'd1);
    checkVal("postRstData",  64'(rd_data),  64'h1234);
    drain();

    // simultaneous write and read request while empty
    wr_valid = 1'b1;
    wr_data  = 32'h5555_AAAA;
    rd_ready = 1'b1;
    checkVal("simulNoValid", 64'(rd_valid), 64'd0);
    cycle();
    checkVal("simulLevel",   64'(level),    64'd1);
    wr_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wc_fifo_fwft.md
WC_FIFO_FWFT -- requirements
Module: wc_fifo_fwft

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: RAM depth is 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 SHALL have parameter AFULL_LVL, default 2**ADDR_WIDTH-2: almost-full threshold, in words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr_valid, input, 1 bit: write word offered.
REQ-007 SHALL have port wr_ready, output, 1 bit: write word accepted this cycle when wr_valid is also high.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH bits: write word.
REQ-009 SHALL have port rd_valid, output, 1 bit: rd_data holds the head word.
REQ-010 SHALL have port rd_ready, input, 1 bit: consumer takes the head word this cycle when rd_valid is also high.
REQ-011 SHALL have port rd_data, output, DATA_WIDTH bits: head word (first-word-fall-through).
REQ-012 SHALL have port level, output, ADDR_WIDTH+1 bits: words held, RAM plus output stage.
REQ-013 SHALL have port afull, output, 1 bit: almost-full flag.

Function
REQ-014 SHALL accept a write when wr_valid=1 and wr_ready=1, storing wr_data at wr_ptr and incrementing wr_ptr modulo 2**ADDR_WIDTH.
REQ-015 SHALL drive wr_ready=0 only when the RAM holds 2**ADDR_WIDTH words; a write is never accepted while the RAM is full.
REQ-016 SHALL issue a RAM read (RAM read latency is 1 cycle) when the RAM is non-empty and the output stage is empty, or is being consumed this cycle; rd_ptr increments modulo 2**ADDR_WIDTH on issue.
REQ-017 SHALL present rd_data and rd_valid with no added register after RAM read data returns: a write handshake in cycle N into an empty FIFO gives rd_valid=1 in cycle N+2.
REQ-018 SHALL hold rd_data and rd_valid stable while rd_valid=1 and rd_ready=0, using an internal hold register, so that no word is lost or duplicated.
REQ-019 SHALL sustain one write and one read per cycle in steady state once the FIFO is non-empty.
REQ-020 SHALL treat rd_ready while rd_valid=0 as a no-op.
REQ-021 SHALL produce no read and no level change in cycle N from a simultaneous write and read request when the FIFO is empty in cycle N.
REQ-022 SHALL accept a simultaneous write and a head consume when the RAM is full, as one combined cycle: the consume frees a slot only from the next cycle.
REQ-023 SHALL update level as +1 on a write, -1 on a consume, and unchanged when both occur; maximum level is 2**ADDR_WIDTH+1.
REQ-024 SHALL preserve word order exactly across pointer wrap-around.

Reset
REQ-025 SHALL, with rst=1 at a rising edge, clear wr_ptr, rd_ptr, level, hold-register valid, and the in-flight read flag.
REQ-026 SHALL hold the following outputs at their reset values from the cycle after that edge: rd_valid=0, wr_ready=1, level=0, afull=0, rd_data=0.
REQ-027 SHALL discard a read in flight when reset occurs mid-operation; RAM contents are not cleared, and the FIFO reads as empty.

Configuration
REQ-028 SHALL, with macro WC_FIFO_AFULL_EN defined, drive afull=1 whenever level >= AFULL_LVL, registered and updated together with level.
REQ-029 SHALL, with WC_FIFO_AFULL_EN undefined, tie afull to 0 and synthesize no comparator; AFULL_LVL is then ignored.

Structure
REQ-030 SHALL place the AFULL_LVL default derivation and the level-width helper constant in the shared bridge package; pointer and level types derive from ADDR_WIDTH.
REQ-031 SHALL instantiate the existing fifo_1rd1wr as its storage sub-module, with both ports on clk, write on port A, and read on port B; the FSM, pointers, and output stage stay in wc_fifo_fwft.

Verification
REQ-032 SHALL cover: ADDR_WIDTH=4, single write 0xA5A5_0001 at cycle N, rd_ready=0 -> rd_valid=1 at N+2, rd_data=0xA5A5_0001, level=1.
REQ-033 SHALL cover: 17 writes with rd_ready=0 -> level=17, wr_ready=0 after the 16th RAM word, afull=1 from level 14 (macro on) or always 0 (macro off).
REQ-034 SHALL cover: full FIFO, rd_ready toggled 1/0 each cycle with wr_valid=1 -> output equals the input sequence, no loss or duplication, level stays within 16..17.
REQ-035 SHALL cover: 40 words continuous, wr_valid=rd_ready=1 -> one word per cycle after 2-cycle fill, in order across two pointer wraps.
REQ-036 SHALL cover: rst=1 for one cycle with level=9 and a read in flight -> next cycle rd_valid=0, level=0, wr_ready=1; subsequent write 0x1234 reads back as the first word.
REQ-037 SHALL cover: wr_valid=1 and rd_ready=1 while empty -> no rd_valid in that cycle, level=1 in the next cycle.
